saturador_pwm_gen: RTL and testbench
====================================

SATURADOR_PWM_GEN -- requirements
Module: saturador_pwm_gen

Interface
REQ-001 Parameter IN_W, 28: signed two's-complement input sample width.
REQ-002 Parameter OUT_W, 11: output/duty width; PWM resolution.
REQ-003 Parameter LSB_POS, 4: input bit index mapped to output LSB.
REQ-004 Parameter NUM_CH, 2: number of PWM channels; CH_W = max(1, clog2(NUM_CH)).
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge system clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 dato_in  in  IN_W  signed sample.
REQ-009 dato_valid  in  1  one-cycle strobe qualifying dato_in/dato_ch.
REQ-010 dato_ch  in  CH_W  target channel of the sample.
REQ-011 dato_out  out  OUT_W  last converted offset-binary value.
REQ-012 sat_hi  out  1  one-cycle pulse: last accepted sample clipped to max.
REQ-013 sat_lo  out  1  one-cycle pulse: last accepted sample clipped to min.
REQ-014 period_start  out  1  one-cycle pulse when the PWM counter is 0.
REQ-015 pwm_out  out  NUM_CH  per-channel PWM outputs.

Function
REQ-016 Conversion SHALL take bits [LSB_POS+OUT_W-1:LSB_POS] as a signed OUT_W field and emit offset binary (MSB inverted).
REQ-017 If bits [IN_W-1:LSB_POS+OUT_W-1] are not all equal, the sample SHALL saturate: sign 0 -> all ones with sat_hi; sign 1 -> all zeros with sat_lo.
REQ-018 Bits below LSB_POS SHALL be discarded (truncation toward -inf) unless REQ-031 applies.
REQ-019 On dato_valid with dato_ch < NUM_CH: dato_out, sat_hi/sat_lo and that channel's shadow duty register SHALL update on the next rising edge (latency 1).
REQ-020 dato_valid with dato_ch >= NUM_CH SHALL be ignored: no register change, no pulse.
REQ-021 sat_hi/sat_lo SHALL be low in every cycle not directly following an accepted sample.
REQ-022 One shared counter SHALL count 0 .. 2^OUT_W-2 and wrap to 0 (period 2^OUT_W-1 clocks).
REQ-023 When the counter is 2^OUT_W-2, each active duty register SHALL load its shadow on the same edge the counter wraps.
REQ-024 pwm_out[i] SHALL be registered and high in the cycle after the counter value c satisfies c < active_duty[i]: duty 0 -> constantly low; all ones -> constantly high.
REQ-025 Sample written on the same edge as the wrap: the active register takes the old shadow; the new value applies one period later.
REQ-026 Multiple samples to one channel within a period: only the last is applied at the wrap.

Reset
REQ-027 While reset is high at a rising edge: counter, shadow and active duties, dato_out, sat_hi, sat_lo and pwm_out SHALL be 0; period_start SHALL be 1 in the first cycle after reset.
REQ-028 Reset mid-period SHALL discard pending shadows; dato_valid during reset SHALL be ignored.

Configuration
REQ-029 Macro SATURADOR_PWM_ROUND_EN selects rounding.
REQ-030 Without it: truncation per REQ-018.
REQ-031 With it: add 2^(LSB_POS-1) to the discarded-bit position before REQ-017 is applied; overflow caused by rounding saturates to all ones with sat_hi. Latency is unchanged.

Structure
REQ-032 Default parameter values and the offset-binary min/max constants SHALL live in the shared package saturador_pwm_pkg.
REQ-033 Saturation and rounding logic SHALL be a combinational sub-module saturador_fx (IN_W, OUT_W, LSB_POS); the top holds the counter, the duty registers and the pulses.

Verification (defaults; ROUND off unless stated)
REQ-034 dato_in=28'h0001230, ch0 -> dato_out=11'h523, no sat pulse.
REQ-035 dato_in=28'h0004000 -> 11'h7FF, sat_hi; 28'hFFF0000 -> 11'h000, sat_lo; 28'hFFFFFF0 -> 11'h3FF, no pulse.
REQ-036 28'h0001238: ROUND off -> 11'h523; ROUND on -> 11'h524. 28'h0003FF8 with ROUND on -> 11'h7FF plus sat_hi.
REQ-037 ch0 duty 11'h400, ch1 duty 11'h7FF -> after the next wrap, ch0 is high 1024 of 2047 clocks and ch1 is continuously high; period_start fires every 2047 clocks.
REQ-038 Sample on the wrap edge -> old duty used for one period, new duty the next; dato_ch=2 (out of range) -> no change; reset mid-period -> all outputs 0 and the counter restarts at 0.

Source files
------------

// File: rtl/saturador_pwm_pkg.sv
// Shared defaults, offset-binary limits and saturation status for the saturating PWM generator.
package saturador_pwm_pkg;

  localparam int unsigned InWDef    = 28;
  localparam int unsigned OutWDef   = 11;
  localparam int unsigned LsbPosDef = 4;
  localparam int unsigned NumChDef  = 2;

  // Offset-binary limits, wide enough for any OUT_W up to 32; users slice [OUT_W-1:0].
  localparam logic [31:0] ObMax = 32'hFFFF_FFFF;
  localparam logic [31:0] ObMin = 32'h0000_0000;

  typedef enum logic [1:0] {
    SatNone = 2'b00,
    SatHi   = 2'b01,
    SatLo   = 2'b10
  } sat_e;

endpackage

// File: rtl/saturador_fx.sv
// Combinational fixed-point narrowing: signed IN_W sample to offset-binary OUT_W with saturation.
// Define SATURADOR_PWM_ROUND_EN to round to nearest instead of truncating toward -inf.
module saturador_fx
  import saturador_pwm_pkg::*;
#(
  parameter int unsigned IN_W    = InWDef,
  parameter int unsigned OUT_W   = OutWDef,
  parameter int unsigned LSB_POS = LsbPosDef
) (
  input  logic [IN_W-1:0]  dato_i,
  output logic [OUT_W-1:0] val_o,
  output sat_e             sat_o
);

  // One guard bit so the rounding add can never wrap the sign.
  localparam int unsigned XW    = IN_W + 1;
  localparam int unsigned TopLo = LSB_POS + OUT_W - 1;

`ifdef SATURADOR_PWM_ROUND_EN
  localparam logic [XW-1:0] RoundAdd = (LSB_POS > 0) ? (XW'(1) << (LSB_POS - 1)) : '0;
`endif

  logic [XW-1:0]       x;
  logic [XW-1-TopLo:0] top;
  logic                in_range;
  logic                unused_low;

  always_comb begin
    x = {dato_i[IN_W-1], dato_i};
`ifdef SATURADOR_PWM_ROUND_EN
    x = x + RoundAdd;
`endif
    top      = x[XW-1:TopLo];
    in_range = (&top) | ~(|top);
    val_o    = {~x[TopLo], x[TopLo-1:LSB_POS]};
    sat_o    = SatNone;
    if (!in_range) begin
      if (!x[XW-1]) begin
        val_o = ObMax[OUT_W-1:0];
        sat_o = SatHi;
      end else begin
        val_o = ObMin[OUT_W-1:0];
        sat_o = SatLo;
      end
    end
  end

  assign unused_low = ^x[LSB_POS-1:0];

endmodule

// File: rtl/saturador_pwm_gen.sv
// Multi-channel PWM generator fed by saturated samples; duties are double-buffered per period.
// Build option SATURADOR_PWM_ROUND_EN enables rounding inside saturador_fx.
module saturador_pwm_gen
  import saturador_pwm_pkg::*;
#(
  parameter int unsigned IN_W    = InWDef,
  parameter int unsigned OUT_W   = OutWDef,
  parameter int unsigned LSB_POS = LsbPosDef,
  parameter int unsigned NUM_CH  = NumChDef,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_W-1:0]   dato_in,
  input  logic              dato_valid,
  input  logic [CH_W-1:0]   dato_ch,
  output logic [OUT_W-1:0]  dato_out,
  output logic              sat_hi,
  output logic              sat_lo,
  output logic              period_start,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam logic [OUT_W-1:0] CntMax = {{(OUT_W - 1){1'b1}}, 1'b0};
  localparam logic [CH_W:0]    NumCh  = (CH_W + 1)'(NUM_CH);

  logic [OUT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  shadow_q [NUM_CH];
  logic [OUT_W-1:0]  shadow_d [NUM_CH];
  logic [OUT_W-1:0]  active_q [NUM_CH];
  logic [OUT_W-1:0]  active_d [NUM_CH];
  logic [OUT_W-1:0]  dato_out_q, dato_out_d;
  logic              sat_hi_q, sat_hi_d;
  logic              sat_lo_q, sat_lo_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;

  logic [OUT_W-1:0]  conv_val;
  sat_e              conv_sat;
  logic              accept;
  logic              wrap;

  saturador_fx #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .LSB_POS(LSB_POS)
  ) u_fx (
    .dato_i(dato_in),
    .val_o (conv_val),
    .sat_o (conv_sat)
  );

  assign accept = dato_valid && ({1'b0, dato_ch} < NumCh);
  assign wrap   = (cnt_q == CntMax);

  always_comb begin
    cnt_d      = wrap ? '0 : cnt_q + 1'b1;
    shadow_d   = shadow_q;
    active_d   = active_q;
    dato_out_d = dato_out_q;
    sat_hi_d   = 1'b0;
    sat_lo_d   = 1'b0;
    pwm_d      = '0;
    if (accept) begin
      dato_out_d = conv_val;
      sat_hi_d   = (conv_sat == SatHi);
      sat_lo_d   = (conv_sat == SatLo);
      for (int i = 0; i < NUM_CH; i++) begin
        if (dato_ch == CH_W'(i)) shadow_d[i] = conv_val;
      end
    end
    // Active duties take the shadow as it stood before this edge's sample.
    if (wrap) active_d = shadow_q;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = (cnt_q < active_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      shadow_q   <= '{default: '0};
      active_q   <= '{default: '0};
      dato_out_q <= '0;
      sat_hi_q   <= 1'b0;
      sat_lo_q   <= 1'b0;
      pwm_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      dato_out_q <= dato_out_d;
      sat_hi_q   <= sat_hi_d;
      sat_lo_q   <= sat_lo_d;
      pwm_q      <= pwm_d;
    end
  end

  assign dato_out     = dato_out_q;
  assign sat_hi       = sat_hi_q;
  assign sat_lo       = sat_lo_q;
  assign period_start = (cnt_q == '0);
  assign pwm_out      = pwm_q;

endmodule

// File: tb/tb_saturador_pwm_gen.sv
// Scoreboard bench for saturador_pwm_gen: conversion/saturation, PWM duty per period, reset.
module tb_saturador_pwm_gen;

  localparam int Period = 2047;

  logic        clk = 1'b0;
  logic        reset;
  logic [27:0] dato_in;
  logic        dato_valid;
  logic [0:0]  dato_ch;
  logic [10:0] dato_out;
  logic        sat_hi, sat_lo, period_start;
  logic [1:0]  pwm_out;

  logic        valid3;
  logic [1:0]  dato_ch3;
  logic [10:0] dato_out3;
  logic        sat_hi3, sat_lo3, period_start3;
  logic [2:0]  pwm_out3;

  int          n_cmp = 0;
  int          n_err = 0;
  int          mcnt  = 0;
  logic [10:0] last_out;
  logic [12:0] sb_q[$];

  always #5 clk = ~clk;

  saturador_pwm_gen u_dut (
    .clk         (clk),
    .reset       (reset),
    .dato_in     (dato_in),
    .dato_valid  (dato_valid),
    .dato_ch     (dato_ch),
    .dato_out    (dato_out),
    .sat_hi      (sat_hi),
    .sat_lo      (sat_lo),
    .period_start(period_start),
    .pwm_out     (pwm_out)
  );

  saturador_pwm_gen #(.NUM_CH(3)) u_dut3 (
    .clk         (clk),
    .reset       (reset),
    .dato_in     (dato_in),
    .dato_valid  (valid3),
    .dato_ch     (dato_ch3),
    .dato_out    (dato_out3),
    .sat_hi      (sat_hi3),
    .sat_lo      (sat_lo3),
    .period_start(period_start3),
    .pwm_out     (pwm_out3)
  );

  // Reference period counter.
  always @(posedge clk) begin
    if (reset) mcnt <= 0;
    else       mcnt <= (mcnt == Period - 1) ? 0 : mcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {sat_hi, sat_lo, value}, computed arithmetically on the integer value.
  function automatic logic [12:0] ref_conv(input logic [27:0] d);
    longint v;
    v = longint'($signed(d));
`ifdef SATURADOR_PWM_ROUND_EN
    v = v + 8;
`endif
    v = v >>> 4;
    if (v > 1023)  return {2'b10, 11'h7FF};
    if (v < -1024) return {2'b01, 11'h000};
    return {2'b00, 11'(v + 1024)};
  endfunction

  task automatic send(input logic [27:0] d, input logic ch, input logic [12:0] exp);
    logic [12:0] e;
    dato_in    = d;
    dato_ch    = ch;
    dato_valid = 1'b1;
    sb_q.push_back(exp);
    tick();
    dato_valid = 1'b0;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      last_out = e[10:0];
      check("dato_out", 32'(dato_out), 32'(e[10:0]));
      check("sat_hi", 32'(sat_hi), 32'(e[12]));
      check("sat_lo", 32'(sat_lo), 32'(e[11]));
    end
  endtask

  task automatic idle_check();
    tick();
    check("idle_sat_hi", 32'(sat_hi), 32'd0);
    check("idle_sat_lo", 32'(sat_lo), 32'd0);
    check("idle_hold", 32'(dato_out), 32'(last_out));
  endtask

  task automatic do_reset(input logic with_valid);
    reset      = 1'b1;
    dato_valid = with_valid;
    dato_in    = 28'h0004000;
    dato_ch    = 1'b1;
    repeat (2) tick();
    reset      = 1'b0;
    dato_valid = 1'b0;
    last_out   = '0;
    sb_q.delete();
    check("rst_dato_out", 32'(dato_out), 32'd0);
    check("rst_sat", 32'({sat_hi, sat_lo}), 32'd0);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_period_start", 32'(period_start), 32'd1);
  endtask

  task automatic wait_cnt(input int target);
    int guard = 0;
    while (mcnt != target && guard < Period + 10) begin
      tick();
      guard++;
    end
    if (mcnt != target) check("wait_timeout", 32'(guard), 32'(target));
  endtask

  // Measures one whole period: from counter 1 through the next counter 0.
  task automatic run_period(output int hi0, output int hi1, output int ps);
    hi0 = 0;
    hi1 = 0;
    ps  = 0;
    wait_cnt(1);
    for (int k = 0; k < Period; k++) begin
      hi0 += int'(pwm_out[0]);
      hi1 += int'(pwm_out[1]);
      if (period_start) ps += (mcnt == 0) ? 1 : 100;
      tick();
    end
  endtask

  logic [27:0] dir_in  [8];
  logic [12:0] dir_exp [8];
  logic        dir_ch  [8];

  initial begin
    int h0, h1, ps;
    logic [27:0] d;

    dir_in[0] = 28'h0001230; dir_exp[0] = {2'b00, 11'h523}; dir_ch[0] = 1'b0;
    dir_in[1] = 28'h0004000; dir_exp[1] = {2'b10, 11'h7FF}; dir_ch[1] = 1'b1;
    dir_in[2] = 28'hFFF0000; dir_exp[2] = {2'b01, 11'h000}; dir_ch[2] = 1'b0;
    dir_in[3] = 28'hFFFFFF0; dir_exp[3] = {2'b00, 11'h3FF}; dir_ch[3] = 1'b1;
`ifdef SATURADOR_PWM_ROUND_EN
    dir_in[4] = 28'h0001238; dir_exp[4] = {2'b00, 11'h524}; dir_ch[4] = 1'b0;
    dir_in[5] = 28'h0003FF8; dir_exp[5] = {2'b10, 11'h7FF}; dir_ch[5] = 1'b1;
`else
    dir_in[4] = 28'h0001238; dir_exp[4] = {2'b00, 11'h523}; dir_ch[4] = 1'b0;
    dir_in[5] = 28'h0003FF8; dir_exp[5] = {2'b00, 11'h7FF}; dir_ch[5] = 1'b1;
`endif
    dir_in[6] = 28'hFFFC000; dir_exp[6] = {2'b00, 11'h000}; dir_ch[6] = 1'b0;
    dir_in[7] = 28'h7FFFFFF; dir_exp[7] = {2'b10, 11'h7FF}; dir_ch[7] = 1'b1;

    valid3   = 1'b0;
    dato_ch3 = 2'd0;
    do_reset(1'b0);
    check("rst_dut3_out", 32'(dato_out3), 32'd0);
    tick();
    check("period_start_low", 32'(period_start), 32'd0);

    for (int i = 0; i < 8; i++) begin
      send(dir_in[i], dir_ch[i], dir_exp[i]);
      idle_check();
    end
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 1) d = 28'($urandom);
      else            d = 28'(int'($urandom_range(40000, 0)) - 20000);
      send(d, 1'($urandom), ref_conv(d));
      idle_check();
    end

    // Out-of-range channel on the three-channel instance.
    dato_in = 28'h0001230; dato_ch3 = 2'd2; valid3 = 1'b1;
    tick();
    valid3 = 1'b0;
    check("ch2_accept", 32'(dato_out3), 32'h523);
    dato_in = 28'h0004000; dato_ch3 = 2'd3; valid3 = 1'b1;
    tick();
    valid3 = 1'b0;
    check("ch3_ignored_out", 32'(dato_out3), 32'h523);
    check("ch3_ignored_sat", 32'({sat_hi3, sat_lo3}), 32'd0);

    // Duty 0x400 on ch0, full scale on ch1.
    do_reset(1'b0);
    send(28'h0000000, 1'b0, {2'b00, 11'h400});
    send(28'h0003FF0, 1'b1, {2'b00, 11'h7FF});
    run_period(h0, h1, ps);
    check("pwm0_half", 32'(h0), 32'd1024);
    check("pwm1_full", 32'(h1), 32'd2047);
    check("period_start_once", 32'(ps), 32'd1);

    // Sample landing on the wrap edge applies one period late.
    wait_cnt(Period - 1);
    send(28'hFFFD000, 1'b0, {2'b00, 11'h100});
    run_period(h0, h1, ps);
    check("wrap_old_duty", 32'(h0), 32'd1024);
    check("wrap_ch1_hold", 32'(h1), 32'd2047);
    run_period(h0, h1, ps);
    check("wrap_new_duty", 32'(h0), 32'd256);
    check("period_start_once2", 32'(ps), 32'd1);

    // Several samples in one period: last one wins; duty 0 gives constant low.
    send(28'hFFFE000, 1'b1, {2'b00, 11'h200});
    send(28'hFFFC800, 1'b1, {2'b00, 11'h080});
    send(28'hFFFC000, 1'b0, {2'b00, 11'h000});
    run_period(h0, h1, ps);
    check("last_sample_wins", 32'(h1), 32'd128);
    check("duty_zero", 32'(h0), 32'd0);

    // Reset mid-period with a pending shadow and a sample during reset.
    repeat (500) tick();
    send(28'h0000000, 1'b0, {2'b00, 11'h400});
    tick();
    do_reset(1'b1);
    run_period(h0, h1, ps);
    check("post_rst_pwm0", 32'(h0), 32'd0);
    check("post_rst_pwm1", 32'(h1), 32'd0);
    run_period(h0, h1, ps);
    check("shadow_discard0", 32'(h0), 32'd0);
    check("shadow_discard1", 32'(h1), 32'd0);
    check("post_rst_ps", 32'(ps), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
